// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes and stage control payloads for the pipeline controller.
package ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned CTRL_ALU_W = 3;

  // RV32I major opcodes recognised by the decoder
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_BUBBLE = 7'b0000000;

  // ALU operation classes handed to the EX-stage ALU control
  localparam logic [CTRL_ALU_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [CTRL_ALU_W-1:0] ALU_BR    = 3'b001;
  localparam logic [CTRL_ALU_W-1:0] ALU_R     = 3'b010;
  localparam logic [CTRL_ALU_W-1:0] ALU_JMP   = 3'b011;
  localparam logic [CTRL_ALU_W-1:0] ALU_I     = 3'b100;
  localparam logic [CTRL_ALU_W-1:0] ALU_LUI   = 3'b101;
  localparam logic [CTRL_ALU_W-1:0] ALU_AUIPC = 3'b110;

  // Full control bundle produced in ID and held in ID/EX
  typedef struct packed {
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic [CTRL_ALU_W-1:0] alu_op;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic                  jump;
    logic                  jalr;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Control still needed once an instruction has left EX
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  // Control still needed in write-back
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  // Drop EX-only fields when moving into EX/MEM
  function automatic mem_ctrl_t to_mem_ctrl(input ctrl_t c);
    mem_ctrl_t m;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.mem_to_reg = c.mem_to_reg;
    m.reg_write  = c.reg_write;
    return m;
  endfunction

  // Drop MEM-only fields when moving into MEM/WB
  function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t m);
    wb_ctrl_t w;
    w.mem_to_reg = m.mem_to_reg;
    w.reg_write  = m.reg_write;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control decode with source-register usage flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                rs1_used,
  output logic                rs2_used,
  output logic                illegal,
  output logic                live
);

  // Decode table; anything unrecognised or not valid collapses to a bubble
  always_comb begin
    ctrl     = BUBBLE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    live     = 1'b0;
    if (id_valid) begin
      live = 1'b1;
      case (opcode)
        OP_R: begin
          ctrl.alu_op    = ALU_R;
          ctrl.reg_write = 1'b1;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end
        OP_LOAD: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_op     = ALU_ADD;
          ctrl.alu_src    = 1'b1;
          ctrl.reg_write  = 1'b1;
          rs1_used        = 1'b1;
        end
        OP_IMM: begin
          ctrl.alu_op    = ALU_I;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          rs1_used       = 1'b1;
        end
        OP_STORE: begin
          ctrl.alu_op    = ALU_ADD;
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end
        OP_BRANCH: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALU_BR;
          rs1_used    = 1'b1;
          rs2_used    = 1'b1;
        end
        OP_JAL: begin
          ctrl.alu_op    = ALU_JMP;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.jump      = 1'b1;
        end
        OP_JALR: begin
          ctrl.alu_op    = ALU_JMP;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.jalr      = 1'b1;
          rs1_used       = 1'b1;
        end
        OP_LUI: begin
          ctrl.alu_op    = ALU_LUI;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          ctrl.alu_op    = ALU_AUIPC;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        OP_BUBBLE: begin
          live = 1'b0;
        end
        default: begin
          live    = 1'b0;
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control path: ID decode, load-use hazard, redirect flush, ID/EX, EX/MEM, MEM/WB.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 3,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  id_illegal,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_jalr,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  ctrl_t                 id_ctrl;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  id_live;
  logic                  load_use_c;
  logic                  insert_bubble_c;

  ctrl_t                 id_ex_ctrl;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  mem_ctrl_t             ex_mem_ctrl;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  wb_ctrl_t              mem_wb_ctrl;
  logic [REG_ADDR_W-1:0] mem_wb_rd;

  ctrl_decode u_decode (
    .id_valid (id_valid),
    .opcode   (id_opcode),
    .ctrl     (id_ctrl),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .illegal  (id_illegal),
    .live     (id_live)
  );

  // Load in EX whose destination is a source of the instruction in ID
  always_comb begin
    load_use_c = 1'b0;
    if (HAZARD_EN && id_valid && id_ex_ctrl.mem_read && (id_ex_rd != '0)) begin
      load_use_c = ((id_rs1 == id_ex_rd) && id_rs1_used) ||
                   ((id_rs2 == id_ex_rd) && id_rs2_used);
    end
  end

  // Redirect wins: the ID instruction is squashed anyway, so holding it is pointless
  assign stall           = load_use_c && !ex_redirect;
  assign flush_if_id     = ex_redirect;
  assign insert_bubble_c = ex_redirect || stall;

  // ID/EX register; x0 as destination for anything that is not a live instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_ctrl <= BUBBLE;
      id_ex_rd   <= '0;
    end else if (insert_bubble_c) begin
      id_ex_ctrl <= BUBBLE;
      id_ex_rd   <= '0;
    end else begin
      id_ex_ctrl <= id_ctrl;
      id_ex_rd   <= id_live ? id_rd : '0;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_ctrl <= MEM_BUBBLE;
      ex_mem_rd   <= '0;
    end else begin
      ex_mem_ctrl <= to_mem_ctrl(id_ex_ctrl);
      ex_mem_rd   <= id_ex_rd;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_ctrl <= WB_BUBBLE;
      mem_wb_rd   <= '0;
    end else begin
      mem_wb_ctrl <= to_wb_ctrl(ex_mem_ctrl);
      mem_wb_rd   <= ex_mem_rd;
    end
  end

  assign ex_alu_op     = ALU_OP_W'(id_ex_ctrl.alu_op);
  assign ex_alu_src    = id_ex_ctrl.alu_src;
  assign ex_branch     = id_ex_ctrl.branch;
  assign ex_jump       = id_ex_ctrl.jump;
  assign ex_jalr       = id_ex_ctrl.jalr;
  assign ex_rd         = id_ex_rd;
  assign mem_read      = ex_mem_ctrl.mem_read;
  assign mem_write     = ex_mem_ctrl.mem_write;
  assign mem_rd        = ex_mem_rd;
  assign wb_mem_to_reg = mem_wb_ctrl.mem_to_reg;
  assign wb_reg_write  = mem_wb_ctrl.reg_write;
  assign wb_rd         = mem_wb_rd;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with a HAZARD_EN=0 twin sharing the same stimulus.
module tb_control_pipe;

  localparam int unsigned RW = 5;
  localparam int unsigned AW = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [6:0]    id_opcode;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_redirect;

  logic          stall, flush_if_id, id_illegal;
  logic [AW-1:0] ex_alu_op;
  logic          ex_alu_src, ex_branch, ex_jump, ex_jalr;
  logic [RW-1:0] ex_rd;
  logic          mem_read, mem_write;
  logic [RW-1:0] mem_rd;
  logic          wb_mem_to_reg, wb_reg_write;
  logic [RW-1:0] wb_rd;

  logic          n_stall, n_flush, n_illegal;
  logic [AW-1:0] n_ex_alu_op;
  logic          n_ex_alu_src, n_ex_branch, n_ex_jump, n_ex_jalr;
  logic [RW-1:0] n_ex_rd;
  logic          n_mem_read, n_mem_write;
  logic [RW-1:0] n_mem_rd;
  logic          n_wb_mem_to_reg, n_wb_reg_write;
  logic [RW-1:0] n_wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  control_pipe #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .HAZARD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(stall), .flush_if_id(flush_if_id), .id_illegal(id_illegal),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_rd(ex_rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd)
  );

  control_pipe #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .HAZARD_EN(1'b0)) u_nohz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(n_stall), .flush_if_id(n_flush), .id_illegal(n_illegal),
    .ex_alu_op(n_ex_alu_op), .ex_alu_src(n_ex_alu_src), .ex_branch(n_ex_branch),
    .ex_jump(n_ex_jump), .ex_jalr(n_ex_jalr), .ex_rd(n_ex_rd),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_rd(n_mem_rd),
    .wb_mem_to_reg(n_wb_mem_to_reg), .wb_reg_write(n_wb_reg_write), .wb_rd(n_wb_rd)
  );

  // EX-stage control as one vector: {alu_op, alu_src, branch, jump, jalr, rd}
  logic [11:0] ex_vec;
  logic [25:0] reg_vec;
  logic [25:0] n_reg_vec;
  assign ex_vec    = {ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_jalr, ex_rd};
  assign reg_vec   = {ex_vec, mem_read, mem_write, mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd};
  assign n_reg_vec = {n_ex_alu_op, n_ex_alu_src, n_ex_branch, n_ex_jump, n_ex_jalr, n_ex_rd,
                      n_mem_read, n_mem_write, n_mem_rd, n_wb_mem_to_reg, n_wb_reg_write, n_wb_rd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input logic [RW-1:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    set_id(1'b0, 7'd0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_regs", 32'(reg_vec), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);

    // Straight line R-type through all stages
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
    check("r_no_stall", 32'(stall), 32'd0);
    check("r_legal", 32'(id_illegal), 32'd0);
    check("no_flush", 32'(flush_if_id), 32'd0);
    tick();
    check("r_ex", 32'(ex_vec), 32'({3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5}));
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    tick();
    check("r_mem", 32'({mem_read, mem_write, mem_rd}), 32'({1'b0, 1'b0, 5'd5}));
    tick();
    check("r_wb", 32'({wb_mem_to_reg, wb_reg_write, wb_rd}), 32'({1'b0, 1'b1, 5'd5}));

    // Load-use on rs1: one stall cycle, bubble in EX, then the add proceeds
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
    tick();
    check("lw_ex", 32'(ex_vec), 32'({3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3}));
    set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd6);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_nohz_stall", 32'(n_stall), 32'd0);
    tick();
    check("lu_ex_bubble", 32'(ex_vec), 32'd0);
    check("lu_mem_lw", 32'({mem_read, mem_rd}), 32'({1'b1, 5'd3}));
    check("lu_stall_released", 32'(stall), 32'd0);
    check("lu_nohz_second", 32'(n_stall), 32'd0);
    tick();
    check("lu_add_ex", 32'(ex_vec), 32'({3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6}));
    check("lu_lw_wb", 32'({wb_mem_to_reg, wb_reg_write, wb_rd}), 32'({1'b1, 1'b1, 5'd3}));
    check("lu_mem_bubble", 32'(mem_read), 32'd0);

    // Load to x0 never stalls
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd0, 5'd4, 5'd6);
    check("x0_no_stall", 32'(stall), 32'd0);
    tick();

    // rs2 field only matters for instructions that read rs2
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7);
    tick();
    set_id(1'b1, OP_IMM, 5'd1, 5'd7, 5'd8);
    check("imm_rs2_ignored", 32'(stall), 32'd0);
    set_id(1'b1, OP_STORE, 5'd1, 5'd7, 5'd0);
    check("store_rs2_stall", 32'(stall), 32'd1);
    set_id(1'b0, 7'd0, '0, '0, '0);
    tick();

    // Taken branch in EX squashes the load sitting in ID
    set_id(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd0);
    tick();
    check("beq_ex", 32'(ex_vec), 32'({3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}));
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
    ex_redirect = 1'b1;
    #1;
    check("redir_flush", 32'(flush_if_id), 32'd1);
    check("redir_stall", 32'(stall), 32'd0);
    tick();
    ex_redirect = 1'b0;
    check("redir_ex_bubble", 32'(ex_vec), 32'd0);
    set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd6);
    check("redir_no_use_stall", 32'(stall), 32'd0);
    tick();
    check("redir_mem_no_read", 32'(mem_read), 32'd0);

    // Redirect and load-use together: redirect wins
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
    tick();
    set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd6);
    ex_redirect = 1'b1;
    #1;
    check("prio_stall", 32'(stall), 32'd0);
    check("prio_flush", 32'(flush_if_id), 32'd1);
    tick();
    ex_redirect = 1'b0;
    check("prio_ex_bubble", 32'(ex_vec), 32'd0);
    check("prio_mem_lw", 32'({mem_read, mem_rd}), 32'({1'b1, 5'd3}));

    // jalr / lui / auipc decode
    set_id(1'b1, OP_JALR, 5'd5, 5'd0, 5'd1);
    tick();
    check("jalr_ex", 32'(ex_vec), 32'({3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1}));
    set_id(1'b1, OP_LUI, 5'd0, 5'd0, 5'd2);
    tick();
    check("lui_ex", 32'(ex_vec), 32'({3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2}));
    set_id(1'b1, OP_AUIPC, 5'd0, 5'd0, 5'd4);
    tick();
    check("auipc_ex", 32'(ex_vec), 32'({3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4}));
    check("jalr_wb", 32'({wb_mem_to_reg, wb_reg_write, wb_rd}), 32'({1'b0, 1'b1, 5'd1}));

    // Unknown opcode
    set_id(1'b1, OP_BAD, 5'd1, 5'd2, 5'd9);
    check("bad_illegal", 32'(id_illegal), 32'd1);
    check("bad_illegal_nohz", 32'(n_illegal), 32'd1);
    tick();
    check("bad_ex_zero", 32'(ex_vec), 32'd0);
    set_id(1'b0, OP_BAD, 5'd1, 5'd2, 5'd9);
    check("bad_invalid_legal", 32'(id_illegal), 32'd0);
    tick();

    // Asynchronous reset mid-stream with a live hazard pending
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
    tick();
    set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd6);
    check("pre_reset_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_regs", 32'(reg_vec), 32'd0);
    check("async_reset_regs_nohz", 32'(n_reg_vec), 32'd0);
    check("async_reset_stall", 32'(stall), 32'd0);
    check("async_reset_flush", 32'(n_flush), 32'd0);
    tick();
    check("held_reset_regs", 32'(reg_vec), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
